piso_tx_scheduler: RTL

//  Round-robin scheduler that shares one parallel-in/serial-out shifter among NREQ requesters.

---
 rtl/piso_tx_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one LSB-first parallel-in/serial-out shifter among NREQ requesters.
// Each granted word is loaded for one cycle, then shifted out one bit per TICK_DIV enabled clocks.
module piso_tx_scheduler #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*WIDTH-1:0]           data,
    output logic [NREQ-1:0]                 ack,
    output logic                            so,
    output logic                            frame_vld,
    output logic                            busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] gnt_id
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  shift_reg, shift_next;
    logic [TW-1:0]     tick_cnt_reg, tick_cnt_next;
    logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0]     ptr_reg, ptr_next;
    logic [GW-1:0]     gnt_id_reg, gnt_id_next;

    logic [WIDTH-1:0]  words [NREQ];
    logic [GW-1:0]     pick;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign words[gi] = data[gi*WIDTH +: WIDTH];
            assign ack[gi]   = (state_reg == LOAD) && (gnt_id_reg == GW'(gi));
        end
    endgenerate

    // Scan from the highest offset down so the closest set bit after ptr wins.
    always_comb begin
        int idx;
        pick = '0;
        idx  = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = (int'(ptr_reg) + off) % NREQ;
            if (req[idx[GW-1:0]]) begin
                pick = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        ptr_next      = ptr_reg;
        gnt_id_next   = gnt_id_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_id_next = pick;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                shift_next    = words[gnt_id_reg];
                tick_cnt_next = '0;
                bit_cnt_next  = '0;
                state_next    = SHIFT;
            end
            SHIFT: begin
                // en=0 freezes the bit timer so the current bit simply stretches.
                if (en) begin
                    if (tick_cnt_reg == TW'(TICK_DIV - 1)) begin
                        tick_cnt_next = '0;
                        shift_next    = shift_reg >> 1;
                        bit_cnt_next  = bit_cnt_reg + BW'(1);
                        if (bit_cnt_reg == BW'(WIDTH - 1)) begin
                            state_next = IDLE;
                            ptr_next   = (gnt_id_reg == GW'(NREQ - 1)) ? '0 : gnt_id_reg + GW'(1);
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            ptr_reg      <= '0;
            gnt_id_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            ptr_reg      <= ptr_next;
            gnt_id_reg   <= gnt_id_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign frame_vld = (state_reg == SHIFT);
    assign so        = frame_vld & shift_reg[0];
    assign gnt_id    = gnt_id_reg;

endmodule
